mem_port_arbiter: RTL and testbench

//   Shares the single MAR/RAM port of the SAP-3 memory between two requesters:
//   the CPU control path (requester 0) and a debug/program loader (requester 1).

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory-strobe and bus-source signals shared between the arbiter and its environment.
interface mem_port_arbiter_if #(
    parameter int unsigned BUS_W  = 16,
    parameter int unsigned DATA_W = 8
) ();
    logic              r0_req;
    logic              r0_we;
    logic [BUS_W-1:0]  r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ack;
    logic              r1_req;
    logic              r1_we;
    logic [BUS_W-1:0]  r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ack;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        gnt;
    logic              busy;
    logic              mar_load;
    logic              ram_write;
    logic              mem_en;
    logic              bus_drv;
    logic [BUS_W-1:0]  bus_out;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_ack, r1_ack, rdata, gnt, busy,
        input  mar_load, ram_write, mem_en, bus_drv, bus_out
    );

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_ack, r1_ack, rdata, gnt, busy,
        output mar_load, ram_write, mem_en, bus_drv, bus_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single MAR/RAM port between the CPU (r0) and the debug loader (r1).
// Every output is a register loaded from the next-state decode, so it lines up with the state register.
module mem_port_arbiter #(
    parameter int unsigned BUS_W  = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WRITE, RD, DONE} state_t;

    state_t            state, state_nx;
    logic              gidx, gidx_nx;
    logic              rr, rr_nx;
    logic              we_q, we_nx;
    logic [BUS_W-1:0]  addr_q, addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              capture;

    // Next-state and latched-field selection
    always_comb begin
        state_nx = state;
        gidx_nx  = gidx;
        rr_nx    = rr;
        we_nx    = we_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.r0_req || bus.r1_req) begin
                    // On a tie the requester that was not served last wins
                    if (bus.r0_req && bus.r1_req) gidx_nx = ~rr;
                    else                          gidx_nx = bus.r1_req;
                    we_nx    = gidx_nx ? bus.r1_we    : bus.r0_we;
                    addr_nx  = gidx_nx ? bus.r1_addr  : bus.r0_addr;
                    wdata_nx = gidx_nx ? bus.r1_wdata : bus.r0_wdata;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                if (we_q) begin
                    state_nx = WRITE;
                end else begin
                    state_nx = RD;
                    cnt_nx   = CNT_W'(RD_LAT);
                end
            end
            WRITE: state_nx = DONE;
            RD: begin
                if (cnt == CNT_W'(1)) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                rr_nx    = gidx;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, latched fields and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            gidx          <= 1'b0;
            rr            <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt           <= '0;
            bus.r0_ack    <= 1'b0;
            bus.r1_ack    <= 1'b0;
            bus.rdata     <= '0;
            bus.gnt       <= 2'b00;
            bus.busy      <= 1'b0;
            bus.mar_load  <= 1'b0;
            bus.ram_write <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.bus_drv   <= 1'b0;
            bus.bus_out   <= '0;
        end else begin
            state         <= state_nx;
            gidx          <= gidx_nx;
            rr            <= rr_nx;
            we_q          <= we_nx;
            addr_q        <= addr_nx;
            wdata_q       <= wdata_nx;
            cnt           <= cnt_nx;
            bus.r0_ack    <= (state_nx == DONE) && !gidx_nx;
            bus.r1_ack    <= (state_nx == DONE) && gidx_nx;
            bus.gnt       <= (state_nx == IDLE) ? 2'b00 : (gidx_nx ? 2'b10 : 2'b01);
            bus.busy      <= (state_nx != IDLE);
            bus.mar_load  <= (state_nx == ADDR);
            bus.ram_write <= (state_nx == WRITE);
            bus.mem_en    <= (state_nx == RD);
            bus.bus_drv   <= (state_nx == ADDR) || (state_nx == WRITE);
            if (state_nx == ADDR)       bus.bus_out <= addr_nx;
            else if (state_nx == WRITE) bus.bus_out <= BUS_W'(wdata_nx);
            else                        bus.bus_out <= '0;
            if (capture) bus.rdata <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, sampling and driving on the falling edge.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_port_arbiter_if #(.BUS_W(16), .DATA_W(8)) bus ();

    mem_port_arbiter #(.BUS_W(16), .DATA_W(8), .RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        logic [37:0] outs;
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        outs = {bus.r0_ack, bus.r1_ack, bus.rdata, bus.gnt, bus.busy, bus.mar_load,
                bus.ram_write, bus.mem_en, bus.bus_drv, bus.bus_out};
        n_tests++;
        if (outs !== 38'd0) begin
            n_fail++; $display("FAIL reset_outputs got=%h want=0", outs);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle busy=%b gnt=%b want 0/00", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_write();
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 16'h0040; bus.r0_wdata = 8'hA5;
        @(negedge clk);
        n_tests++;
        if (bus.mar_load !== 1'b1 || bus.bus_drv !== 1'b1 || bus.bus_out !== 16'h0040 ||
            bus.ram_write !== 1'b0 || bus.mem_en !== 1'b0 || bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_cyc1 mar=%b drv=%b out=%h wr=%b en=%b gnt=%b want 1 1 0040 0 0 01",
                     bus.mar_load, bus.bus_drv, bus.bus_out, bus.ram_write, bus.mem_en, bus.gnt);
        end
        @(negedge clk);
        n_tests++;
        if (bus.ram_write !== 1'b1 || bus.bus_drv !== 1'b1 || bus.bus_out !== 16'h00A5 ||
            bus.mar_load !== 1'b0 || bus.mem_en !== 1'b0 || bus.r0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL write_cyc2 wr=%b drv=%b out=%h mar=%b en=%b ack=%b want 1 1 00a5 0 0 0",
                     bus.ram_write, bus.bus_drv, bus.bus_out, bus.mar_load, bus.mem_en, bus.r0_ack);
        end
        @(negedge clk);
        n_tests++;
        if (bus.r0_ack !== 1'b1 || bus.r1_ack !== 1'b0 || bus.mar_load !== 1'b0 || bus.ram_write !== 1'b0 ||
            bus.mem_en !== 1'b0 || bus.bus_drv !== 1'b0) begin
            n_fail++;
            $display("FAIL write_cyc3 r0_ack=%b r1_ack=%b mar=%b wr=%b en=%b drv=%b want 1 0 0 0 0 0",
                     bus.r0_ack, bus.r1_ack, bus.mar_load, bus.ram_write, bus.mem_en, bus.bus_drv);
        end
        bus.r0_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.r0_ack !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
            n_fail++; $display("FAIL write_after ack=%b busy=%b gnt=%b want 0 0 00", bus.r0_ack, bus.busy, bus.gnt);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL write_no_restart busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_read();
        bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 16'h0012; bus.mem_rdata = 8'h3C;
        @(negedge clk);
        n_tests++;
        if (bus.mar_load !== 1'b1 || bus.bus_out !== 16'h0012 || bus.gnt !== 2'b10) begin
            n_fail++; $display("FAIL read_cyc1 mar=%b out=%h gnt=%b want 1 0012 10", bus.mar_load, bus.bus_out, bus.gnt);
        end
        @(negedge clk);
        n_tests++;
        if (bus.mem_en !== 1'b1 || bus.bus_drv !== 1'b0 || bus.mar_load !== 1'b0 || bus.r1_ack !== 1'b0) begin
            n_fail++; $display("FAIL read_cyc2 en=%b drv=%b mar=%b ack=%b want 1 0 0 0",
                               bus.mem_en, bus.bus_drv, bus.mar_load, bus.r1_ack);
        end
        @(negedge clk);
        n_tests++;
        if (bus.r1_ack !== 1'b1 || bus.rdata !== 8'h3C || bus.mem_en !== 1'b0 || bus.r0_ack !== 1'b0) begin
            n_fail++; $display("FAIL read_cyc3 ack=%b rdata=%h en=%b r0_ack=%b want 1 3c 0 0",
                               bus.r1_ack, bus.rdata, bus.mem_en, bus.r0_ack);
        end
        bus.r1_req = 1'b0; bus.mem_rdata = 8'h55;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.rdata !== 8'h3C || bus.r1_ack !== 1'b0) begin
            n_fail++; $display("FAIL read_hold rdata=%h ack=%b want 3c 0", bus.rdata, bus.r1_ack);
        end
    endtask

    task automatic test_round_robin();
        bit seen;
        rst = 1'b0; idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 16'h0100; bus.r0_wdata = 8'h11;
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 16'h0200; bus.r1_wdata = 8'h22;
        @(negedge clk);
        n_tests++;
        if (bus.gnt !== 2'b01 || bus.bus_out !== 16'h0100) begin
            n_fail++; $display("FAIL rr_first gnt=%b out=%h want 01 0100", bus.gnt, bus.bus_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.r0_ack;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL rr_r0_ack timeout got=0 want=1");
        end
        bus.r0_req = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.gnt !== 2'b10 || bus.bus_out !== 16'h0200) begin
            n_fail++; $display("FAIL rr_second gnt=%b out=%h want 10 0200", bus.gnt, bus.bus_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.r1_ack;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL rr_r1_ack timeout got=0 want=1");
        end
        bus.r0_req = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.gnt !== 2'b01) begin
            n_fail++; $display("FAIL rr_alternate gnt=%b want 01", bus.gnt);
        end
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL rr_drain busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 16'h0300; bus.r1_wdata = 8'h77;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.r1_ack !== ((k % 4) == 3) || bus.r0_ack !== 1'b0) begin
                n_fail++; $display("FAIL b2b_ack k=%0d r1_ack=%b r0_ack=%b want %b 0",
                                   k, bus.r1_ack, bus.r0_ack, (k % 4) == 3);
            end
            n_tests++;
            if (bus.gnt !== (((k % 4) == 0) ? 2'b00 : 2'b10)) begin
                n_fail++; $display("FAIL b2b_gnt k=%0d gnt=%b want %b", k, bus.gnt,
                                   ((k % 4) == 0) ? 2'b00 : 2'b10);
            end
        end
        bus.r1_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_in_write();
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 16'h0055; bus.r0_wdata = 8'h66;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.ram_write !== 1'b1) begin
            n_fail++; $display("FAIL rstw_in_write ram_write=%b want 1", bus.ram_write);
        end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if (bus.ram_write !== 1'b0 || bus.busy !== 1'b0 || bus.bus_drv !== 1'b0) begin
            n_fail++; $display("FAIL rstw_async wr=%b busy=%b drv=%b want 0 0 0", bus.ram_write, bus.busy, bus.bus_drv);
        end
        bus.r0_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.r0_ack !== 1'b0) begin
            n_fail++; $display("FAIL rstw_no_ack ack=%b want 0", bus.r0_ack);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00 || bus.r0_ack !== 1'b0) begin
            n_fail++; $display("FAIL rstw_idle busy=%b gnt=%b ack=%b want 0 00 0", bus.busy, bus.gnt, bus.r0_ack);
        end
    endtask

    task automatic test_latched_fields();
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 16'h0077; bus.r0_wdata = 8'h5A;
        @(negedge clk);
        n_tests++;
        if (bus.bus_out !== 16'h0077 || bus.mar_load !== 1'b1) begin
            n_fail++; $display("FAIL latch_addr out=%h mar=%b want 0077 1", bus.bus_out, bus.mar_load);
        end
        bus.r0_req = 1'b0; bus.r0_addr = 16'h0099; bus.r0_wdata = 8'hFF; bus.r0_we = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.ram_write !== 1'b1 || bus.bus_out !== 16'h005A) begin
            n_fail++; $display("FAIL latch_data wr=%b out=%h want 1 005a", bus.ram_write, bus.bus_out);
        end
        @(negedge clk);
        n_tests++;
        if (bus.r0_ack !== 1'b1) begin
            n_fail++; $display("FAIL latch_ack ack=%b want 1", bus.r0_ack);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL latch_idle busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_back_to_back();
        test_reset_in_write();
        test_latched_fields();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
